// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch sequencing controller.
package if_fetch_ctrl_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int PC_STEP_DEF = 4;

  // REQ: a memory request is outstanding; HOLD: an instruction is parked
  // in the hold buffer because the decode side is stalled.
  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencing controller: issues instruction-memory requests at the
// current PC, decides when the PC register loads (sequential step or a
// redirect target) and writes the IF/ID register, inserting bubbles when a
// redirect squashes the fetch stream.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall_in,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_id_load,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  fetch_state_t    state_q, state_d;
  logic            squash_q, squash_d;
  logic [XLEN-1:0] redir_tgt_q, redir_tgt_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  // The request address is simply the current PC; since the PC only loads on
  // a response or a redirect, it stays stable while a request is in flight.
  assign imem_address = pc_in;

  // State, squash flag, pending redirect target and hold buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= REQ;
      squash_q     <= 1'b0;
      redir_tgt_q  <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      squash_q     <= squash_d;
      redir_tgt_q  <= redir_tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  // Next-state and output decode; a redirect always wins over a stall.
  always_comb begin
    state_d      = state_q;
    squash_d     = squash_q;
    redir_tgt_d  = redir_tgt_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    imem_read    = 1'b0;
    pc_load      = 1'b0;
    pc_next      = pc_in + STEP;
    if_id_load   = 1'b0;
    if_id_valid  = 1'b0;
    if_id_instr  = '0;
    if_id_pc     = '0;

    unique case (state_q)
      REQ: begin
        imem_read = 1'b1;
        if (redirect_valid) begin
          if_id_load = 1'b1;
          if (imem_resp) begin
            pc_load  = 1'b1;
            pc_next  = redirect_target;
            squash_d = 1'b0;
          end else begin
            squash_d    = 1'b1;
            redir_tgt_d = redirect_target;
          end
        end else if (imem_resp) begin
          pc_load = 1'b1;
          if (squash_q) begin
            pc_next  = redir_tgt_q;
            squash_d = 1'b0;
          end else if (stall_in) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_in;
            state_d      = HOLD;
          end else begin
            if_id_load  = 1'b1;
            if_id_valid = 1'b1;
            if_id_instr = imem_rdata;
            if_id_pc    = pc_in;
          end
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_load    = 1'b1;
          pc_next    = redirect_target;
          if_id_load = 1'b1;
          state_d    = REQ;
        end else if (!stall_in) begin
          if_id_load  = 1'b1;
          if_id_valid = 1'b1;
          if_id_instr = hold_instr_q;
          if_id_pc    = hold_pc_q;
          state_d     = REQ;
        end
      end

      default: state_d = REQ;
    endcase

    if (rst) begin
      imem_read   = 1'b0;
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      if_id_valid = 1'b0;
      if_id_instr = '0;
      if_id_pc    = '0;
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Sequencing controller for the IF stage. It drives the instruction-memory request handshake and decides when and with what value the PC register loads (pc+4 or a latched redirect target). It also writes the IF/ID pipeline register, inserting bubbles on redirects. It sits between pc_register, the instruction memory port, the EX/MEM branch-resolution path and the hazard unit, and replaces the free-running PC mux.

Parameters:
PC_STEP, 4, increment applied to the PC for sequential fetch.
XLEN, 32, width of PC, address and instruction words.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pc_in  in  XLEN  current PC from pc_register (fetch address)
pc_load  out  1  load enable to pc_register
pc_next  out  XLEN  value pc_register loads when pc_load=1
imem_read  out  1  instruction-memory read request
imem_address  out  XLEN  request address (always equals pc_in)
imem_resp  in  1  one-cycle response strobe
imem_rdata  in  XLEN  instruction word, valid when imem_resp=1
stall_in  in  1  hazard unit: IF/ID must hold
redirect_valid  in  1  EX/MEM resolved taken branch/jump this cycle
redirect_target  in  XLEN  target PC (EX_MEM_alu_out)
if_id_load  out  1  write enable for IF/ID register
if_id_valid  out  1  1 = real instruction, 0 = bubble
if_id_instr  out  XLEN  instruction to IF/ID
if_id_pc  out  XLEN  PC of that instruction

Behaviour:
- Reset (synchronous, active-high): state=REQ, squash=0, hold buffer cleared, redir_pend=0. While rst=1: imem_read=0, pc_load=0, if_id_load=0, if_id_valid=0, if_id_instr=0, if_id_pc=0.
- States: REQ (request outstanding) and HOLD (instruction buffered, downstream stalled).
- REQ: imem_read=1, imem_address=pc_in, held stable until imem_resp. Address never changes while a request is outstanding.
- REQ, resp=1, squash=0, no redirect, stall_in=0: if_id_load=1, valid=1, instr=imem_rdata, pc=pc_in. pc_load=1, pc_next=pc_in+PC_STEP (mod 2^XLEN, wraps). Stay in REQ; the next request issues the following cycle, for a throughput of one instruction per response.
- REQ, resp=1, stall_in=1, no redirect: capture {imem_rdata, pc_in} into the hold buffer. pc_load=1 (pc+4), if_id_load=0, go to HOLD.
- REQ, resp=0: pc_load=0 and if_id_load=0. If stall_in=1, the request stays outstanding.
- HOLD: imem_read=0. While stall_in=1, outputs stay idle. When stall_in=0: if_id_load=1 from the buffer, then go to REQ.
- Redirect in REQ, resp=1 same cycle: discard rdata. pc_load=1, pc_next=redirect_target. if_id_load=1 with valid=0 (flush). Stay in REQ.
- Redirect in REQ, resp=0: latch target into redir_tgt and set squash=1. Flush IF/ID (load=1, valid=0). The request continues. On the later resp, discard the data, pc_load=1, pc_next=redir_tgt, clear squash.
- Redirect while squash=1: the newer target overwrites redir_tgt.
- Redirect in HOLD: drop the buffer, pc_load=1, pc_next=redirect_target, flush IF/ID, go to REQ.
- A redirect overrides stall_in: the flush is written even when stall_in=1.
- pc_load and if_id_load are combinational from state and inputs, registered into pc_register / IF/ID at the next clk edge.
- Reset mid-request: an in-flight response arriving after reset is ignored only if it lands during rst=1. The memory is reset by the same rst.

Decomposition:
- rv32i_types gains fetch_state_t enum {REQ, HOLD}.
- PC_STEP is a localparam default.
- No sub-module is needed. The hold buffer and redirect latch are flops in this block.
- pc_register is reused unchanged, with its load tied to pc_load.

Test Plan:
1. Reset, pc_in=0x60, resp on every 2nd cycle, no stalls: IF/ID sees valid instrs at PCs 0x60, 0x64, 0x68, pc_load pulses once per resp, imem_address stable between resps.
2. stall_in=1 on the cycle resp arrives with rdata=0x00500093: the instr goes to HOLD, imem_read=0, no if_id_load. After 3 stall cycles stall_in=0: if_id_load=1, instr=0x00500093, pc=0x64, and the next request is at 0x68.
3. redirect_valid=1, target=0x200 while waiting (resp 2 cycles later, rdata=0xDEADBEEF): if_id_valid=0 flush, the DEADBEEF response is discarded, pc_next=0x200, then the next fetch address is 0x200.
4. Redirect to 0x300 and resp in the same cycle with stall_in=1: flush is written, pc_next=0x300, no HOLD entry.
5. Two redirects (0x400 then 0x500) before the resp: pc_next=0x500 after the response.
6. pc_in=0xFFFFFFFC, resp: pc_next=0x00000000 (wrap). Assert rst mid-REQ: all outputs return to reset values the next cycle.
